// File: rtl/car_sensor_seq_gen.sv
// car_sensor_seq_gen
//   Transmit side of the two-beam parking-lot sensor interface. Each accepted
//   start request drives the sensor pair ab through the Gray sequence that a
//   passing car produces: 00 -> PH1 -> PH2 -> PH3 -> 00. Each non-idle phase
//   is held for HOLD_CYCLES cycles.
//   Phase values for dir=0: 01, 11, 10. Phase values for dir=1: 10, 11, 01.
//   The direction is latched only when a request is accepted.
//   A start/busy/done handshake frames every pass. abort ends a pass at once.
//
//   Optional feature macro: CAR_BOUNCE_EN
//     When defined, the module gains a `bounce` input. It is sampled in the
//     last cycle of the first PH2 visit. When bounce is high there, the pass
//     rocks back PH2 -> PH1 -> PH2 and then continues to PH3. At most one
//     bounce is allowed per pass.

module car_sensor_seq_gen #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir,
`ifdef CAR_BOUNCE_EN
    input  logic       bounce,
`endif
    input  logic       abort,
    output logic [1:0] ab,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        PH3  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;     // cycles left in the current phase, including this one
    logic             dir_q;     // direction latched at accept
    logic [1:0]       ab_q;
    logic             busy_q;
    logic             done_q;
`ifdef CAR_BOUNCE_EN
    logic             bounced_q; // the single allowed rock-back has been used
`endif

    // ab for the outer phases depends on direction; PH2 is always 11
    function automatic logic [1:0] ph1_ab(input logic d);
        return d ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] ph3_ab(input logic d);
        return d ? 2'b01 : 2'b10;
    endfunction

    // Pass sequencer: state, hold counter and all outputs are updated together,
    // so ab/busy/done are registered and always consistent with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            ab_q      <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CAR_BOUNCE_EN
            bounced_q <= 1'b0;
`endif
        end else begin
            // done is a single-cycle pulse; it is raised again only on the PH3 exit
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // abort while idle also blocks a simultaneous start
                    if (start && !abort) begin
                        dir_q     <= dir;
                        state_q   <= PH1;
                        cnt_q     <= CNT_LOAD;
                        ab_q      <= ph1_ab(dir);
                        busy_q    <= 1'b1;
`ifdef CAR_BOUNCE_EN
                        bounced_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    if (abort) begin
                        // abandon the pass silently: no done pulse
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ab_q    <= 2'b00;
                        busy_q  <= 1'b0;
                    end else if (cnt_q > CNT_ONE) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        // last cycle of the phase: step to the adjacent Gray code
                        case (state_q)
                            PH1: begin
                                state_q <= PH2;
                                cnt_q   <= CNT_LOAD;
                                ab_q    <= 2'b11;
                            end
                            PH2: begin
`ifdef CAR_BOUNCE_EN
                                if (!bounced_q && bounce) begin
                                    // car rocks back: revisit PH1 once
                                    state_q   <= PH1;
                                    cnt_q     <= CNT_LOAD;
                                    ab_q      <= ph1_ab(dir_q);
                                    bounced_q <= 1'b1;
                                end else begin
                                    state_q <= PH3;
                                    cnt_q   <= CNT_LOAD;
                                    ab_q    <= ph3_ab(dir_q);
                                end
`else
                                state_q <= PH3;
                                cnt_q   <= CNT_LOAD;
                                ab_q    <= ph3_ab(dir_q);
`endif
                            end
                            default: begin
                                // PH3 exit: beams clear, pass complete
                                state_q <= IDLE;
                                cnt_q   <= '0;
                                ab_q    <= 2'b00;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign ab   = ab_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
